// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings plus default datapath width
package alu_pkg;
    localparam int WIDTH_DEF = 64;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOR} op_e;
    typedef enum logic {EMPTY, FULL} state_e;
endpackage

// File: rtl/alu_logic_unit.sv
// alu_logic_unit: shared bitwise logic unit, each result bit depends only on a[i], b[i]
module alu_logic_unit import alu_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    // select one of the four bitwise functions
    always_comb begin
        y = op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b : ~(a | b);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one registered logic unit
module alu_arbiter import alu_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_id
);
    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic             id_q;
    logic             last_q;
    logic             can_accept;
    logic             gnt0;
    logic             gnt1;
    op_e              op_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] y;

    // grant when the output slot frees up; on a tie favour the requester not granted last
    always_comb begin
        can_accept = state_q == EMPTY || out_ready;
        gnt0 = rst_n && can_accept && req0_valid && (!req1_valid || last_q);
        gnt1 = rst_n && can_accept && req1_valid && (!req0_valid || !last_q);
        op_d = gnt1 ? op_e'(req1_op) : op_e'(req0_op);
        a_d  = gnt1 ? req1_a : req0_a;
        b_d  = gnt1 ? req1_b : req0_b;
    end

    alu_logic_unit #(.WIDTH(WIDTH)) u_lu (
        .op (op_d),
        .a  (a_d),
        .b  (b_d),
        .y  (y)
    );

    // EMPTY/FULL FSM with the result register; a grant always refills, otherwise a take empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            result_q <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
        end else if (gnt0 || gnt1) begin
            state_q  <= FULL;
            result_q <= y;
            id_q     <= gnt1;
            last_q   <= gnt1;
        end else if (out_ready) begin
            state_q  <= EMPTY;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign out_valid  = state_q == FULL;
    assign out_result = result_q;
    assign out_id     = id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks against a transaction-level model
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [63:0] out_result;
    logic        out_id;

    int total = 0;
    int bad = 0;
    int accepts = 0;

    logic        m_valid;
    logic [63:0] m_result;
    logic        m_id;
    int          m_last;

    alu_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_id(out_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] f(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            case (op)
                2'd0: r[i] = a[i] & b[i];
                2'd1: r[i] = a[i] | b[i];
                2'd2: r[i] = a[i] ^ b[i];
                default: r[i] = !(a[i] | b[i]);
            endcase
        end
        return r;
    endfunction

    function automatic void model_reset();
        m_valid = 1'b0;
        m_result = '0;
        m_id = 1'b0;
        m_last = 1;
    endfunction

    task automatic step(input logic v0, input logic v1, input logic [1:0] o0, input logic [1:0] o1,
                        input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1, input logic ordy);
        int g;
        req0_valid = v0; req1_valid = v1; req0_op = o0; req1_op = o1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1; out_ready = ordy;
        g = -1;
        if (!m_valid || ordy) begin
            if (v0 && v1) g = (m_last == 0) ? 1 : 0;
            else if (v0) g = 0;
            else if (v1) g = 1;
        end
        #1;
        chk("req0_ready", 64'(req0_ready), 64'(g == 0));
        chk("req1_ready", 64'(req1_ready), 64'(g == 1));
        if (g >= 0) accepts++;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_id = (g == 1);
            m_result = g == 1 ? f(o1, a1, b1) : f(o0, a0, b0);
            m_last = g;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_result", out_result, m_result);
        chk("out_id", 64'(out_id), 64'(m_id));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        model_reset();
        #1;
        chk("rst_req0_ready", 64'(req0_ready), 64'd0);
        chk("rst_req1_ready", 64'(req1_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] PB = 64'hFFFF_0000_FFFF_0000;

    initial begin
        logic [63:0] expv [4];
        logic [63:0] held;
        expv[0] = 64'hAAAA_0000_AAAA_0000;
        expv[1] = 64'hFFFF_AAAA_FFFF_AAAA;
        expv[2] = 64'h5555_AAAA_5555_AAAA;
        expv[3] = 64'h0000_5555_0000_5555;

        do_reset();
        step(1, 0, 2'b01, 2'b00, 64'h00FF, 64'h0F00, 64'h0, 64'h0, 1);
        chk("single_result", out_result, 64'h0FFF);
        chk("single_id", 64'(out_id), 64'd0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 2'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 1);
            chk("rr_id_alternates", 64'(out_id), 64'(i % 2));
            chk("rr_no_bubble", 64'(out_valid), 64'd1);
        end

        do_reset();
        accepts = 0;
        for (int i = 0; i < 5; i++)
            step(1, 1, 2'b10, 2'b11, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 0);
        chk("stall_one_accept", 64'(accepts), 64'd1);
        held = m_result;
        chk("stall_result_stable", out_result, held);
        step(1, 1, 2'b00, 2'b01, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, 1);
        chk("stall_release_accept", 64'(accepts), 64'd2);

        for (int k = 0; k < 4; k++) begin
            step(1, 0, 2'(k), 2'b00, PA, PB, 64'h0, 64'h0, 1);
            chk("op_pattern", out_result, expv[k]);
        end

        step(0, 1, 2'b00, 2'b10, 64'h0, 64'h0, PA, PB, 1);
        chk("full_before_reset", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(out_valid), 64'd0);
        chk("midreset_result", out_result, 64'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1, 1, 2'b01, 2'b01, 64'h1, 64'h2, 64'h4, 64'h8, 1);
        chk("post_reset_tie_id", 64'(out_id), 64'd0);

        held = out_result;
        step(0, 0, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 1);
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_result_kept", out_result, held);

        for (int i = 0; i < 300; i++)
            step(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
